// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed 7-segment driver: shadows a packed nibble word and scans one
// digit per refresh slot. Decoding supports hex glyphs, leading-zero blanking, dp and polarity.
module sevenseg_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit HEX_EN      = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] data,
  input  logic                load,
  input  logic                blank_lz,
  input  logic [DIGITS-1:0]   dp_in,
  output logic [6:0]          segments,
  output logic                dp,
  output logic [DIGITS-1:0]   anodes
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   dp_shadow;
  logic [CNT_W-1:0]    count;
  logic [IDX_W-1:0]    idx;
  logic                tick;

  logic [3:0]          nibble [DIGITS];
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;
  logic [DIGITS-1:0]   an_nxt;

  // Active-high glyphs; segment order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1110011;
      4'hA:    seg = HEX_EN ? 7'b1110111 : 7'b0000000;
      4'hB:    seg = HEX_EN ? 7'b0011111 : 7'b0000000;
      4'hC:    seg = HEX_EN ? 7'b1001110 : 7'b0000000;
      4'hD:    seg = HEX_EN ? 7'b0111101 : 7'b0000000;
      4'hE:    seg = HEX_EN ? 7'b1001111 : 7'b0000000;
      default: seg = HEX_EN ? 7'b1000111 : 7'b0000000;
    endcase
    return seg;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      dp_shadow <= '0;
    end else if (load) begin
      shadow    <= data;
      dp_shadow <= dp_in;
    end
  end

  assign tick = (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      idx   <= '0;
    end else begin
      count <= tick ? '0 : count + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) nibble[i] = shadow[4*i +: 4];
  end

  // A digit is a leading zero when it and every digit above it hold zero.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (nibble[i] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  always_comb begin
    seg_nxt = decode(nibble[idx]);
    dp_nxt  = dp_shadow[idx];
    an_nxt  = '0;
    for (int i = 0; i < DIGITS; i++) an_nxt[i] = (idx == IDX_W'(i));
    if (blank_lz && lz_mask[idx]) begin
      seg_nxt = '0;
      dp_nxt  = 1'b0;
      an_nxt  = '0;
    end
  end

  // Polarity is applied at the register so reset drives the inactive level too.
  always_ff @(posedge clk) begin
    if (rst) begin
      segments <= {7{ACTIVE_LOW}};
      dp       <= ACTIVE_LOW;
      anodes   <= {DIGITS{ACTIVE_LOW}};
    end else begin
      segments <= seg_nxt ^ {7{ACTIVE_LOW}};
      dp       <= dp_nxt ^ ACTIVE_LOW;
      anodes   <= an_nxt ^ {DIGITS{ACTIVE_LOW}};
    end
  end

endmodule
